sample_mixer: RTL
=================

# sample_mixer

Time-multiplexed voice mixer directly downstream of `shifter`. It accepts one arithmetically scaled signed sample per cycle, one per voice, in voice order. It sums each frame of `VOICES` samples in a widened accumulator, saturates the sum back to `WIDTH` bits, and presents the mixed sample to the codec interface through a one-entry valid/ready output register. It also drives the current voice index so the upstream shifter can select per-voice distance and direction.

## Interface
- `WIDTH`, 16: sample width; two's complement.
- `VOICES`, 4: samples per frame; power of two, 2 to 16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in_sample` input `WIDTH`: signed scaled sample from `shifter`.
- `in_valid` input 1: `in_sample` is valid this cycle.
- `in_ready` output 1: mixer accepts `in_sample` this cycle.
- `voice` output `$clog2(VOICES)`: index of the voice expected next; equals the frame counter.
- `out_sample` output `WIDTH`: saturated mixed sample.
- `out_clip` output 1: the frame in `out_sample` saturated.
- `out_valid` output 1: `out_sample` and `out_clip` are valid.
- `out_ready` input 1: consumer accepts the output this cycle.

## Operation
- Accumulator `acc` is signed and `ACCW = WIDTH + $clog2(VOICES)` bits wide. `in_sample` is sign-extended to `ACCW` before adding, so no overflow is possible inside `acc`.
- An input transfer occurs when `in_valid && in_ready`.
- Non-final transfer (`voice != VOICES-1`): `acc <= acc + in_sample`, `voice <= voice + 1`.
- Final transfer (`voice == VOICES-1`):
  - `sum = acc + in_sample`.
  - If `sum > 2^(WIDTH-1)-1`, `out_sample <= 2^(WIDTH-1)-1` and `out_clip <= 1`.
  - If `sum < -2^(WIDTH-1)`, `out_sample <= -2^(WIDTH-1)` and `out_clip <= 1`.
  - Otherwise `out_sample <= sum[WIDTH-1:0]` and `out_clip <= 0`.
  - Also `out_valid <= 1`, `acc <= 0`, `voice <= 0` (wrap).
- Two-state FSM, tracked by `out_valid`:
  - EMPTY (`out_valid = 0`): `in_ready = 1`. A final transfer moves to FULL.
  - FULL (`out_valid = 1`):
    - `in_ready = 1` when `voice != VOICES-1`.
    - When `voice == VOICES-1`, `in_ready = out_ready`. The final sample of the next frame is accepted only in the cycle the held output drains.
    - `out_ready` with no final transfer in the same cycle moves to EMPTY (`out_valid <= 0`).
    - `out_ready` together with a final transfer stays FULL, loading the new frame with no bubble.
- `in_ready` is combinational from `out_valid`, `voice` and `out_ready` only. It must never depend on `in_valid`.
- `out_sample` and `out_clip` are held stable while `out_valid && !out_ready`.
- `in_valid` low: no state change to `acc` or `voice`. Gaps mid-frame are allowed indefinitely.

## Timing
- Reset values: `acc = 0`, `voice = 0`, `out_sample = 0`, `out_clip = 0`, `out_valid = 0`, `in_ready = 1`.
- Latency: `out_valid` rises on the clock edge that accepts the final sample; the output is visible the following cycle.
- Throughput: one mixed sample per `VOICES` input transfers; sustained with `out_ready` held high.
- `voice` changes only on transfer edges. Upstream uses it in the same cycle to pick the shift settings applied to `in_sample`.
- Reset asserted mid-frame or with output held: the partial sum and pending output are discarded; the next frame starts at `voice = 0`.
- Simultaneous drain and final transfer: the new frame wins; `out_valid` stays 1.

## Test plan
- Reset, then 4 transfers of 100, 200, -50, 7 with `out_ready = 1`:
  - `voice` steps 0→1→2→3→0.
  - `out_sample = 257`, `out_clip = 0`; `out_valid` high for 1 cycle.
- Four inputs of 16384 each (sum 65536): `out_sample = 32767`, `out_clip = 1`. Four inputs of -16384, -16384, -16384, -1: `out_sample = -32768`, `out_clip = 1`.
- Exact boundary: 32767, 0, 0, 0 gives 32767 with `out_clip = 0`; 32767, 1, 0, 0 gives 32767 with `out_clip = 1`.
- Backpressure, `out_ready = 0` after a frame completes, `in_valid` held high:
  - Voices 0–2 of the next frame are accepted.
  - `in_ready = 0` at voice 3 and `out_sample` stays stable.
  - Raising `out_ready` accepts voice 3 in that cycle; `out_valid` stays 1 with the new sum.
- Continuous stream of 8 frames with `out_ready = 1` and random `in_valid` gaps: each output equals the saturated reference sum of its frame; no frame is lost or duplicated.
- Assert `reset` asynchronously after 2 of 4 samples, and again while `out_valid = 1`:
  - All outputs return to reset values without waiting for a clock edge.
  - The next frame of 1, 2, 3, 4 yields 10.

Source files
------------

// File: rtl/sample_mixer.sv
// sample_mixer: sums VOICES time-multiplexed samples per frame, saturates, and holds the mix in a valid/ready output register
module sample_mixer #(
    parameter int WIDTH  = 16,
    parameter int VOICES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WIDTH-1:0]     in_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [$clog2(VOICES)-1:0]   voice,
    output logic signed [WIDTH-1:0]     out_sample,
    output logic                        out_clip,
    output logic                        out_valid,
    input  logic                        out_ready
);
    localparam int VW   = $clog2(VOICES);
    localparam int ACCW = WIDTH + VW;
    localparam logic signed [ACCW-1:0] MAXV = ACCW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  sum;
    logic signed [WIDTH-1:0] sat;
    logic                    last, xfer, hi, lo;

    assign out_valid = state == FULL;
    assign last      = voice == VW'(VOICES - 1);
    // a held output only blocks the frame-closing sample, and only until it drains
    assign in_ready  = state == EMPTY || !last || out_ready;
    assign xfer      = in_valid && in_ready;

    // widened running sum and its saturated narrow form
    always_comb begin
        sum = acc + {{VW{in_sample[WIDTH-1]}}, in_sample};
        hi  = sum > MAXV;
        lo  = sum < MINV;
        sat = hi ? MAXV[WIDTH-1:0] : lo ? MINV[WIDTH-1:0] : sum[WIDTH-1:0];
    end

    // accumulate per voice; the final sample loads the output register, a drain without one empties it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            acc        <= '0;
            voice      <= '0;
            out_sample <= '0;
            out_clip   <= 1'b0;
        end else begin
            if (xfer) begin
                acc   <= last ? '0 : sum;
                voice <= last ? '0 : voice + VW'(1);
            end
            if (xfer && last) begin
                out_sample <= sat;
                out_clip   <= hi || lo;
                state      <= FULL;
            end else if (out_ready) begin
                state      <= EMPTY;
            end
        end
    end
endmodule
